// File: rtl/scan_mux.sv
// scan_mux: registered CHANNELS-to-1 mux with manual select and timed auto-scan
module scan_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 10,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      enable,
    input  logic                      mode,
    input  logic                      load,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      wrap,
    output logic                      sel_err
);
    localparam int DW_W = $clog2(DWELL + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MANUAL = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             wrap_q, wrap_d;
    logic             wrap_pend_q, wrap_pend_d;
    logic             sel_err_q, sel_err_d;
    logic             scan, man, last_dwell, last_ch, bad_sel, step;

    // The state entered on this edge governs what the edge does, so a mode
    // change and a load arriving together follow the new mode. Manual mode
    // pins the dwell counter at 0, which makes every entry into SCAN from
    // MANUAL start a fresh dwell while a re-enable after a freeze resumes.
    always_comb begin
        state_d     = !enable ? IDLE : (mode ? SCAN : MANUAL);
        scan        = state_d == SCAN;
        man         = state_d == MANUAL;
        last_dwell  = dwell_q == DW_W'(DWELL - 1);
        last_ch     = cur_sel_q == SEL_W'(CHANNELS - 1);
        bad_sel     = {1'b0, sel_in} >= (SEL_W + 1)'(CHANNELS);
        step        = scan && last_dwell;
        cur_sel_d   = step ? (last_ch ? '0 : cur_sel_q + 1'b1)
                    : (man && load && !bad_sel) ? sel_in : cur_sel_q;
        dwell_d     = scan ? (last_dwell ? '0 : dwell_q + 1'b1) : (man ? '0 : dwell_q);
        wrap_pend_d = enable ? (step && last_ch) : wrap_pend_q;
        wrap_d      = enable && wrap_pend_q;
        sel_err_d   = sel_err_q || (man && load && bad_sel);
        out_data_d  = enable ? in_data[int'(cur_sel_q)*WIDTH +: WIDTH] : out_data_q;
        out_sel_d   = enable ? cur_sel_q : out_sel_q;
    end

    // All state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_sel_q   <= '0;
            dwell_q     <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            wrap_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            dwell_q     <= dwell_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            wrap_q      <= wrap_d;
            wrap_pend_q <= wrap_pend_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = state_q != IDLE;
    assign wrap      = wrap_q;
    assign sel_err   = sel_err_q;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: three scan_mux configurations checked against a rule-level model
module tb_scan_mux;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mode = 1'b0, load = 1'b0;
    logic [2:0]  sel_in = '0;
    logic [31:0] din = '0;
    logic [3:0]  o_data [3];
    logic [2:0]  o_sel [3];
    logic [1:0]  sel3;
    logic        o_valid [3], o_wrap [3], o_err [3];
    int          checks = 0, errors = 0;

    int          CHN [3] = '{8, 5, 3};
    int          DW  [3] = '{2, 2, 1};
    int          SW  [3] = '{3, 3, 2};
    int          m_ch [3], m_spent [3], m_sel [3];
    logic [3:0]  m_data [3];
    bit          m_valid [3], m_wrap [3], m_err [3], m_wpend [3];

    always #5 clk = ~clk;
    assign o_sel[2] = {1'b0, sel3};

    scan_mux #(.WIDTH(4), .CHANNELS(8), .DWELL(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(din), .enable(enable), .mode(mode), .load(load),
        .sel_in(sel_in), .out_data(o_data[0]), .out_sel(o_sel[0]), .out_valid(o_valid[0]),
        .wrap(o_wrap[0]), .sel_err(o_err[0]));
    scan_mux #(.WIDTH(4), .CHANNELS(5), .DWELL(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(din[19:0]), .enable(enable), .mode(mode), .load(load),
        .sel_in(sel_in), .out_data(o_data[1]), .out_sel(o_sel[1]), .out_valid(o_valid[1]),
        .wrap(o_wrap[1]), .sel_err(o_err[1]));
    scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(din[11:0]), .enable(enable), .mode(mode), .load(load),
        .sel_in(sel_in[1:0]), .out_data(o_data[2]), .out_sel(sel3), .out_valid(o_valid[2]),
        .wrap(o_wrap[2]), .sel_err(o_err[2]));

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ch[i] = 0; m_spent[i] = 0; m_sel[i] = 0; m_data[i] = '0;
            m_valid[i] = 0; m_wrap[i] = 0; m_err[i] = 0; m_wpend[i] = 0;
        end
    endtask

    // Scan: each channel is shown DWELL times, then the next one modulo CHANNELS.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int si = int'(sel_in) % (1 << SW[i]);
            if (!enable) begin
                m_valid[i] = 0; m_wrap[i] = 0;
            end else begin
                m_data[i]  = 4'((din >> (4 * m_ch[i])) & 32'hf);
                m_sel[i]   = m_ch[i];
                m_valid[i] = 1;
                m_wrap[i]  = m_wpend[i];
                m_wpend[i] = 0;
                if (mode) begin
                    m_spent[i]++;
                    if (m_spent[i] == DW[i]) begin
                        m_spent[i] = 0;
                        m_wpend[i] = m_ch[i] == CHN[i] - 1;
                        m_ch[i]    = (m_ch[i] + 1) % CHN[i];
                    end
                end else begin
                    m_spent[i] = 0;
                    if (load) begin
                        if (si < CHN[i]) m_ch[i] = si;
                        else m_err[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; din = '1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_data[i] !== 4'h0 || o_sel[i] !== 3'd0 || o_valid[i] !== 1'b0 || o_wrap[i] !== 1'b0 || o_err[i] !== 1'b0) begin
                errors++; $display("FAIL reset_hold[%0d] got d=%0h s=%0d v=%0b w=%0b e=%0b want all 0", i, o_data[i], o_sel[i], o_valid[i], o_wrap[i], o_err[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_data[i] !== 4'h0 || o_sel[i] !== 3'd0 || o_valid[i] !== 1'b0 || o_wrap[i] !== 1'b0 || o_err[i] !== 1'b0) begin
                errors++; $display("FAIL reset_idle[%0d] got d=%0h s=%0d v=%0b w=%0b e=%0b want all 0", i, o_data[i], o_sel[i], o_valid[i], o_wrap[i], o_err[i]);
            end
        end
    endtask

    task automatic test_manual();
        for (int k = 0; k < 8; k++) din[k*4 +: 4] = 4'(k + 3);
        enable = 1'b1; mode = 1'b0; load = 1'b1; sel_in = 3'd5;
        tick();
        load = 1'b0;
        tick();
        checks++; if (o_data[0] !== 4'd8 || o_sel[0] !== 3'd5 || o_valid[0] !== 1'b1) begin
            errors++; $display("FAIL manual_sel5 got d=%0d s=%0d v=%0b want d=8 s=5 v=1", o_data[0], o_sel[0], o_valid[0]);
        end
        load = 1'b1; sel_in = 3'd0;
        tick();
        load = 1'b0;
        tick();
        checks++; if (o_data[0] !== 4'd3 || o_sel[0] !== 3'd0) begin
            errors++; $display("FAIL manual_sel0 got d=%0d s=%0d want d=3 s=0", o_data[0], o_sel[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_data[i] !== m_data[i] || o_sel[i] !== 3'(m_sel[i]) || o_err[i] !== m_err[i]) begin
                errors++; $display("FAIL manual_model[%0d] got d=%0h s=%0d e=%0b want d=%0h s=%0d e=%0b", i, o_data[i], o_sel[i], o_err[i], m_data[i], m_sel[i], m_err[i]);
            end
        end
    endtask

    task automatic test_scan();
        int wraps [3] = '{0, 0, 0};
        int want_wraps [3] = '{1, 1, 5};
        mode = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++; if (o_sel[i] !== 3'((k / DW[i]) % CHN[i]) || o_wrap[i] !== m_wrap[i] || o_data[i] !== m_data[i]) begin
                    errors++; $display("FAIL scan_seq[%0d] k=%0d got s=%0d w=%0b d=%0h want s=%0d w=%0b d=%0h", i, k, o_sel[i], o_wrap[i], o_data[i], (k / DW[i]) % CHN[i], m_wrap[i], m_data[i]);
                end
                if (o_wrap[i] === 1'b1) wraps[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wraps[i] != want_wraps[i]) begin
                errors++; $display("FAIL scan_wraps[%0d] got %0d want %0d", i, wraps[i], want_wraps[i]);
            end
        end
    endtask

    task automatic test_bad_sel();
        #2;
        pulse_reset();
        enable = 1'b1; mode = 1'b0; load = 1'b1; sel_in = 3'd2;
        tick();
        sel_in = 3'd6;
        tick();
        load = 1'b0;
        tick();
        checks++; if (o_sel[1] !== 3'd2 || o_err[1] !== 1'b1) begin
            errors++; $display("FAIL bad_sel_ch5 got s=%0d e=%0b want s=2 e=1", o_sel[1], o_err[1]);
        end
        checks++; if (o_sel[0] !== 3'd6 || o_err[0] !== 1'b0) begin
            errors++; $display("FAIL bad_sel_ch8 got s=%0d e=%0b want s=6 e=0", o_sel[0], o_err[0]);
        end
        repeat (3) tick();
        load = 1'b1; sel_in = 3'd1;
        tick();
        load = 1'b0;
        tick();
        checks++; if (o_sel[1] !== 3'd1 || o_err[1] !== 1'b1) begin
            errors++; $display("FAIL bad_sel_sticky got s=%0d e=%0b want s=1 e=1", o_sel[1], o_err[1]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_err[i] !== m_err[i] || o_sel[i] !== 3'(m_sel[i])) begin
                errors++; $display("FAIL bad_sel_model[%0d] got s=%0d e=%0b want s=%0d e=%0b", i, o_sel[i], o_err[i], m_sel[i], m_err[i]);
            end
        end
    endtask

    task automatic test_freeze();
        mode = 1'b0; load = 1'b1; sel_in = 3'd3;
        tick();
        load = 1'b0; mode = 1'b1;
        tick();
        enable = 1'b0;
        repeat (5) begin
            tick();
            checks++; if (o_valid[0] !== 1'b0 || o_sel[0] !== 3'd3 || o_data[0] !== m_data[0]) begin
                errors++; $display("FAIL freeze_hold got v=%0b s=%0d d=%0h want v=0 s=3 d=%0h", o_valid[0], o_sel[0], o_data[0], m_data[0]);
            end
        end
        enable = 1'b1;
        tick();
        checks++; if (o_sel[0] !== 3'd3 || o_valid[0] !== 1'b1) begin
            errors++; $display("FAIL freeze_resume got s=%0d v=%0b want s=3 v=1", o_sel[0], o_valid[0]);
        end
        tick();
        checks++; if (o_sel[0] !== 3'd4) begin
            errors++; $display("FAIL freeze_next got s=%0d want s=4", o_sel[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_sel[i] !== 3'(m_sel[i]) || o_data[i] !== m_data[i]) begin
                errors++; $display("FAIL freeze_model[%0d] got s=%0d d=%0h want s=%0d d=%0h", i, o_sel[i], o_data[i], m_sel[i], m_data[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        din = $urandom;
        enable = 1'b1; mode = 1'b1;
        while (o_sel[0] !== 3'd6 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (o_sel[0] !== 3'd6) begin
            errors++; $display("FAIL async_reach_ch6 got s=%0d want 6 within 40 cycles", o_sel[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_data[i] !== 4'h0 || o_sel[i] !== 3'd0 || o_valid[i] !== 1'b0 || o_wrap[i] !== 1'b0) begin
                errors++; $display("FAIL async_clear[%0d] got d=%0h s=%0d v=%0b w=%0b want all 0", i, o_data[i], o_sel[i], o_valid[i], o_wrap[i]);
            end
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_sel[0] !== 3'(k / 2) || o_data[0] !== m_data[0] || o_valid[0] !== 1'b1) begin
                errors++; $display("FAIL async_restart k=%0d got s=%0d d=%0h v=%0b want s=%0d d=%0h v=1", k, o_sel[0], o_data[0], o_valid[0], k / 2, m_data[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            enable = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            load   = $urandom_range(0, 3) == 0;
            sel_in = 3'($urandom_range(0, 7));
            din    = $urandom;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++; if (o_data[i] !== m_data[i] || o_sel[i] !== 3'(m_sel[i]) || o_valid[i] !== m_valid[i] || o_wrap[i] !== m_wrap[i] || o_err[i] !== m_err[i]) begin
                    errors++; $display("FAIL random[%0d] c=%0d got d=%0h s=%0d v=%0b w=%0b e=%0b want d=%0h s=%0d v=%0b w=%0b e=%0b",
                        i, c, o_data[i], o_sel[i], o_valid[i], o_wrap[i], o_err[i], m_data[i], m_sel[i], m_valid[i], m_wrap[i], m_err[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_manual();
        test_scan();
        test_bad_sel();
        test_freeze();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
